// File: rtl/bcd_display_scanner.sv
// Multiplexed 4-digit common-anode 7-segment scanner for BCD time digits.
// Inputs are captured once per frame; colon blinks every BLINK_FRAMES frames.
module bcd_display_scanner #(
    parameter int PRESCALE     = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dhour,
    input  logic [3:0] uhour,
    input  logic [3:0] dmin,
    input  logic [3:0] umin,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] pre_p0;
    logic [1:0]    idx_p0;
    logic [FW-1:0] fcnt_p0;
    logic          blink_p0;
    logic [3:0]    snap_dh_p0, snap_uh_p0, snap_dm_p0, snap_um_p0;

    logic          tick;
    logic          frame_end;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick      = (pre_p0 == PW'(PRESCALE - 1));
    assign frame_end = tick && (idx_p0 == 2'd3);

    always_comb begin
        digit = snap_um_p0;
        case (idx_p0)
            2'd0:    digit = snap_um_p0;
            2'd1:    digit = snap_dm_p0;
            2'd2:    digit = snap_uh_p0;
            default: digit = snap_dh_p0;
        endcase
        // blank_lz is deliberately live, only the digit value comes from the snapshot
        blank = (idx_p0 == 2'd3) && blank_lz && (snap_dh_p0 == 4'd0);
    end

    // Stage p0: prescaler, slot index, frame snapshot and blink state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_p0     <= '0;
            idx_p0     <= '0;
            fcnt_p0    <= '0;
            blink_p0   <= 1'b0;
            snap_dh_p0 <= '0;
            snap_uh_p0 <= '0;
            snap_dm_p0 <= '0;
            snap_um_p0 <= '0;
        end else begin
            pre_p0 <= tick ? '0 : pre_p0 + 1'b1;
            if (tick)
                idx_p0 <= idx_p0 + 2'd1;
            if (frame_end) begin
                snap_dh_p0 <= dhour;
                snap_uh_p0 <= uhour;
                snap_dm_p0 <= dmin;
                snap_um_p0 <= umin;
                if (fcnt_p0 == FW'(BLINK_FRAMES - 1)) begin
                    fcnt_p0  <= '0;
                    blink_p0 <= ~blink_p0;
                end else begin
                    fcnt_p0 <= fcnt_p0 + 1'b1;
                end
            end
        end
    end

    // Stage p1: registered display drive, one cycle behind idx
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            if (blank) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
            end else begin
                an  <= ~(4'b0001 << idx_p0);
                seg <= bcd_to_seg(digit);
            end
            dp <= ~((idx_p0 == 2'd2) && blink_p0);
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner against a frame/slot-level time model.
module tb_bcd_display_scanner;

    localparam int P     = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * P;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] dhour = '0, uhour = '0, dmin = '0, umin = '0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16];
    logic [3:0] m_dh, m_uh, m_dm, m_um;
    int         edge_n;

    bcd_display_scanner #(.PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset),
        .dhour(dhour), .uhour(uhour), .dmin(dmin), .umin(umin),
        .blank_lz(blank_lz),
        .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        m_dh = '0; m_uh = '0; m_dm = '0; m_um = '0;
    endtask

    // Expected output after edge n reflects time t=n-1 since reset release:
    // slot = (t/P)%4, frame = t/FRAME, blink = (frame/BF)%2.
    task automatic step();
        int t, slot, f;
        logic [3:0] d;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dp;
        @(posedge clk);
        edge_n++;
        t    = edge_n - 1;
        slot = (t / P) % 4;
        f    = t / FRAME;
        case (slot)
            0:       d = m_um;
            1:       d = m_dm;
            2:       d = m_uh;
            default: d = m_dh;
        endcase
        if (slot == 3 && blank_lz && m_dh == 4'd0) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
        end else begin
            e_an       = 4'b1111;
            e_an[slot] = 1'b0;
            e_seg      = seg_tab[d];
        end
        e_dp = !(slot == 2 && ((f / BF) % 2) == 1);
        if (edge_n % FRAME == 0) begin
            m_dh = dhour; m_uh = uhour; m_dm = dmin; m_um = umin;
        end
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
    endtask

    task automatic rand_cycle(input int dh_max);
        @(negedge clk);
        dhour    = 4'($urandom_range(0, dh_max));
        uhour    = 4'($urandom_range(0, 15));
        dmin     = 4'($urandom_range(0, 15));
        umin     = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic hold_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
        model_reset();

        // Power-up reset
        #2 reset = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        dhour = 4'd2; uhour = 4'd3; dmin = 4'd5; umin = 4'd9; blank_lz = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Directed 23:59 sequence
        hold_cycles(16);
        step();
        check("e17_seg9", 32'(seg), 32'b0010000);
        check("e17_an", 32'(an), 32'b1110);
        hold_cycles(3); step();
        check("e21_seg5", 32'(seg), 32'b0010010);
        hold_cycles(3); step();
        check("e25_seg3", 32'(seg), 32'b0110000);
        hold_cycles(3); step();
        check("e29_seg2", 32'(seg), 32'b0100100);
        hold_cycles(3);

        // Leading-zero blanking, then non-zero tens of hours, then invalid BCD
        @(negedge clk);
        dhour = 4'd0; uhour = 4'd7; dmin = 4'd4; umin = 4'd1; blank_lz = 1'b1;
        hold_cycles(2 * FRAME);
        @(negedge clk);
        dhour = 4'd1;
        hold_cycles(2 * FRAME);
        @(negedge clk);
        umin = 4'hC; blank_lz = 1'b0;
        hold_cycles(2 * FRAME);

        // Inputs change every clock; only frame-end samples may appear
        for (int i = 0; i < 8 * FRAME; i++) rand_cycle(2);
        for (int i = 0; i < 4 * FRAME; i++) rand_cycle(15);

        // Advance to slot 2 and reset between clock edges
        for (int i = 0; i < FRAME && ((edge_n / P) % 4) != 2; i++) rand_cycle(2);
        check("mid_slot2", 32'((edge_n / P) % 4), 32'd2);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_dp", 32'(dp), 32'h1);
        @(posedge clk);
        #1;
        check("hold_rst_an", 32'(an), 32'hF);
        @(negedge clk);
        dhour = 4'd1; uhour = 4'd8; dmin = 4'd3; umin = 4'd6; blank_lz = 1'b0;
        reset = 1'b0;
        model_reset();
        step();
        check("rel_an", 32'(an), 32'b1110);
        check("rel_seg0", 32'(seg), 32'b1000000);
        for (int i = 0; i < 6 * FRAME; i++) rand_cycle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
